morse_tx: RTL

Parametrised Morse transmitter for the lab 5 datapath, extending the 8-letter, 12-bit fixed-pattern sender. It accepts a 6-bit symbol code (A–Z, 0–9) and expands the standard ITU dot/dash code into unit-timed marks and spaces: dot = 1 unit on, dash = 3 units on, inter-element space = 1 unit off. It adds a Busy/Done/Error handshake, a synchronous Abort, and a Repeat mode that inserts a 3-unit letter gap and replays the symbol. It drives the LEDR output the same way the earlier sender did.

---
 rtl/morse_pkg.sv | 60 ++++++
 rtl/morse_unit_timer.sv | 28 ++
 rtl/morse_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and the ITU symbol table for the Morse transmitter.
package morse_pkg;

    localparam int unsigned NUM_SYMBOLS = 36;
    localparam int unsigned MAX_ELEMS   = 5;

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    // Element vector: 1 = dash, element 0 at MSB, left aligned.
    typedef struct packed {
        logic [MAX_ELEMS-1:0] code;
        logic [2:0]           len;
    } sym_t;

    function automatic sym_t sym_code(input logic [5:0] letter);
        sym_t s;
        s = '0;
        case (letter)
            6'd0:  s = {5'b01000, 3'd2};  // A .-
            6'd1:  s = {5'b10000, 3'd4};  // B -...
            6'd2:  s = {5'b10100, 3'd4};  // C -.-.
            6'd3:  s = {5'b10000, 3'd3};  // D -..
            6'd4:  s = {5'b00000, 3'd1};  // E .
            6'd5:  s = {5'b00100, 3'd4};  // F ..-.
            6'd6:  s = {5'b11000, 3'd3};  // G --.
            6'd7:  s = {5'b00000, 3'd4};  // H ....
            6'd8:  s = {5'b00000, 3'd2};  // I ..
            6'd9:  s = {5'b01110, 3'd4};  // J .---
            6'd10: s = {5'b10100, 3'd3};  // K -.-
            6'd11: s = {5'b01000, 3'd4};  // L .-..
            6'd12: s = {5'b11000, 3'd2};  // M --
            6'd13: s = {5'b10000, 3'd2};  // N -.
            6'd14: s = {5'b11100, 3'd3};  // O ---
            6'd15: s = {5'b01100, 3'd4};  // P .--.
            6'd16: s = {5'b11010, 3'd4};  // Q --.-
            6'd17: s = {5'b01000, 3'd3};  // R .-.
            6'd18: s = {5'b00000, 3'd3};  // S ...
            6'd19: s = {5'b10000, 3'd1};  // T -
            6'd20: s = {5'b00100, 3'd3};  // U ..-
            6'd21: s = {5'b00010, 3'd4};  // V ...-
            6'd22: s = {5'b01100, 3'd3};  // W .--
            6'd23: s = {5'b10010, 3'd4};  // X -..-
            6'd24: s = {5'b10110, 3'd4};  // Y -.--
            6'd25: s = {5'b11000, 3'd4};  // Z --..
            6'd26: s = {5'b11111, 3'd5};  // 0
            6'd27: s = {5'b01111, 3'd5};  // 1
            6'd28: s = {5'b00111, 3'd5};  // 2
            6'd29: s = {5'b00011, 3'd5};  // 3
            6'd30: s = {5'b00001, 3'd5};  // 4
            6'd31: s = {5'b00000, 3'd5};  // 5
            6'd32: s = {5'b10000, 3'd5};  // 6
            6'd33: s = {5'b11000, 3'd5};  // 7
            6'd34: s = {5'b11100, 3'd5};  // 8
            6'd35: s = {5'b11110, 3'd5};  // 9
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running unit timer; tick_c is high in the last cycle of each unit.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 250
) (
    input  logic ClockIn,
    input  logic Reset,
    input  logic restart,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(UNIT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge ClockIn) begin
        if (Reset)
            cnt <= '0;
        else if (restart || cnt == '0)
            cnt <= CW'(UNIT_CYCLES - 1);
        else
            cnt <= cnt - CW'(1);
    end

    assign tick_c = (cnt == '0);

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: expands a latched symbol into unit-timed marks/spaces with handshake.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500,
    parameter int unsigned TICKS_PER_SEC   = 2
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Repeat,
    input  logic [5:0] Letter,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int unsigned UNIT_CYCLES = CLOCK_FREQUENCY / TICKS_PER_SEC;

    if (UNIT_CYCLES < 1) begin : g_bad_unit
        $error("morse_tx: UNIT_CYCLES must be at least 1");
    end

    state_t               state, state_n;
    logic [MAX_ELEMS-1:0] code, code_n;
    logic [2:0]           len, len_n;
    logic [2:0]           idx, idx_n, idx_nx;
    logic [1:0]           ul, ul_n;
    logic                 restart, tick;
    logic                 nb_n, done_n, err_n;
    sym_t                 sc;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .restart (restart),
        .tick_c  (tick)
    );

    assign sc     = sym_code(Letter);
    assign idx_nx = idx + 3'd1;

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state      <= IDLE;
            code       <= '0;
            len        <= '0;
            idx        <= '0;
            ul         <= '0;
            DotDashOut <= 1'b0;
            NewBitOut  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            state      <= state_n;
            code       <= code_n;
            len        <= len_n;
            idx        <= idx_n;
            ul         <= ul_n;
            DotDashOut <= (state_n == MARK);
            NewBitOut  <= nb_n;
            Busy       <= (state_n != IDLE);
            Done       <= done_n;
            Error      <= err_n;
        end
    end

    // ul counts the units still to run in the current mark or gap after this one.
    always_comb begin
        state_n = state;
        code_n  = code;
        len_n   = len;
        idx_n   = idx;
        ul_n    = ul;
        restart = 1'b0;
        nb_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Letter < 6'(NUM_SYMBOLS)) begin
                        state_n = MARK;
                        code_n  = sc.code;
                        len_n   = sc.len;
                        idx_n   = '0;
                        ul_n    = sc.code[MAX_ELEMS-1] ? 2'd2 : 2'd0;
                        restart = 1'b1;
                        nb_n    = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (tick) begin
                    if (ul != 2'd0) begin
                        ul_n = ul - 2'd1;
                        nb_n = 1'b1;
                    end else if (idx != len - 3'd1) begin
                        state_n = SPACE;
                        nb_n    = 1'b1;
                    end else if (Repeat) begin
                        state_n = GAP;
                        ul_n    = 2'd2;
                        nb_n    = 1'b1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    state_n = MARK;
                    idx_n   = idx_nx;
                    ul_n    = code[3'(MAX_ELEMS - 1) - idx_nx] ? 2'd2 : 2'd0;
                    nb_n    = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    nb_n = 1'b1;
                    if (ul != 2'd0) begin
                        ul_n = ul - 2'd1;
                    end else begin
                        state_n = MARK;
                        idx_n   = '0;
                        ul_n    = code[MAX_ELEMS-1] ? 2'd2 : 2'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (Abort) begin
            state_n = IDLE;
            restart = 1'b0;
            nb_n    = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b0;
        end
    end

endmodule
